// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared encodings and widths for the branch predictor
//
// Purpose: 2-bit direction counter encodings, the counter reset and
// allocation values, and the statistics counter width.
// Ports: none (package).
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    localparam int BP_STAT_W = 16;

endpackage

// File: rtl/sat_ctr2.sv
// rtl/sat_ctr2.sv - 2-bit saturating counter next-state function
//
// Purpose: combinational increment/decrement with clamping at the ends.
// Ports:
//   ctr  in  2 : current counter value
//   inc  in  1 : 1 = step toward strong taken, 0 = step toward strong not-taken
//   next out 2 : updated counter value
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] next
);

    always_comb begin
        next = ctr;
        if (inc) begin
            if (ctr != CTR_ST) next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters
//
// Purpose: zero-latency next-PC prediction for fetch, trained by branches
// resolved in EX. Optional statistics counters under macro BP_STATS_EN.
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   F_pc                in  XLEN  current fetch PC
//   F_BP_target_pc      out XLEN  predicted next fetch PC
//   F_BP_taken          out 1     prediction is taken
//   EX_br_valid         in  1     a branch resolves this cycle
//   EX_pc               in  XLEN  PC of resolving branch
//   EX_actual_taken     in  1     resolved direction
//   EX_actual_target    in  XLEN  resolved target
//   EX_pred_taken       in  1     prediction carried with the branch
//   EX_pred_target      in  XLEN  predicted target carried with the branch
//   stat_branches       out 16    resolved branches (BP_STATS_EN only)
//   stat_mispredicts    out 16    mispredicts (BP_STATS_EN only)
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 5,
    parameter int IDX_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] F_pc,
    output logic [XLEN-1:0] F_BP_target_pc,
    output logic            F_BP_taken,
    input  logic            EX_br_valid,
    input  logic [XLEN-1:0] EX_pc,
    input  logic            EX_actual_taken,
    input  logic [XLEN-1:0] EX_actual_target,
    input  logic            EX_pred_taken,
    input  logic [XLEN-1:0] EX_pred_target
`ifdef BP_STATS_EN
    ,
    output logic [BP_STAT_W-1:0] stat_branches,
    output logic [BP_STAT_W-1:0] stat_mispredicts
`endif
);

    localparam int N     = 1 << IDX_BITS;
    localparam int TAG_W = XLEN - IDX_BITS;

    // Table kept in flops so the asynchronous reset can clear every entry.
    logic             valid_q  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [XLEN-1:0]  target_q [N];
    logic [1:0]       ctr_q    [N];

    // Lookup
    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic                f_hit;

    assign f_idx = F_pc[IDX_BITS-1:0];
    assign f_tag = F_pc[XLEN-1:IDX_BITS];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign F_BP_taken     = f_hit && ctr_q[f_idx][1];
    assign F_BP_target_pc = F_BP_taken ? target_q[f_idx] : F_pc + 1'b1;

    // Update
    logic [IDX_BITS-1:0] e_idx;
    logic [TAG_W-1:0]    e_tag;
    logic                e_hit;
    logic [1:0]          ctr_next;

    assign e_idx = EX_pc[IDX_BITS-1:0];
    assign e_tag = EX_pc[XLEN-1:IDX_BITS];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    sat_ctr2 u_sat_ctr2 (
        .ctr  (ctr_q[e_idx]),
        .inc  (EX_actual_taken),
        .next (ctr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (EX_br_valid) begin
            if (e_hit) begin
                ctr_q[e_idx] <= ctr_next;
                if (EX_actual_taken) target_q[e_idx] <= EX_actual_target;
            end else if (EX_actual_taken) begin
                // Allocate on taken miss, evicting whatever aliases here.
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= EX_actual_target;
                ctr_q[e_idx]    <= CTR_ALLOC;
            end
        end
    end

`ifdef BP_STATS_EN
    logic mispredict;

    // Target only matters when both sides agree the branch was taken.
    assign mispredict = (EX_pred_taken != EX_actual_taken) ||
                        (EX_pred_taken && EX_actual_taken &&
                         (EX_pred_target != EX_actual_target));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (EX_br_valid) begin
            stat_branches <= stat_branches + 1'b1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`else
    // Prediction carry-along inputs exist only for pipeline wiring here.
    logic unused_pred;
    assign unused_pred = ^{EX_pred_taken, EX_pred_target};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

    localparam int XLEN     = 5;
    localparam int IDX_BITS = 2;
    localparam int N        = 1 << IDX_BITS;
    localparam int PC_MOD   = 1 << XLEN;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] F_pc;
    logic [XLEN-1:0] F_BP_target_pc;
    logic            F_BP_taken;
    logic            EX_br_valid;
    logic [XLEN-1:0] EX_pc;
    logic            EX_actual_taken;
    logic [XLEN-1:0] EX_actual_target;
    logic            EX_pred_taken;
    logic [XLEN-1:0] EX_pred_target;
`ifdef BP_STATS_EN
    logic [15:0]     stat_branches;
    logic [15:0]     stat_mispredicts;
`endif

    branch_predictor #(.XLEN(XLEN), .IDX_BITS(IDX_BITS)) dut (
        .clk              (clk),
        .rst              (rst),
        .F_pc             (F_pc),
        .F_BP_target_pc   (F_BP_target_pc),
        .F_BP_taken       (F_BP_taken),
        .EX_br_valid      (EX_br_valid),
        .EX_pc            (EX_pc),
        .EX_actual_taken  (EX_actual_taken),
        .EX_actual_target (EX_actual_target),
        .EX_pred_taken    (EX_pred_taken),
        .EX_pred_target   (EX_pred_target)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: a table of plain integers, counter 0..3.
    bit m_valid  [N];
    int m_tag    [N];
    int m_target [N];
    int m_ctr    [N];
    int m_branches;
    int m_mispredicts;

    function automatic bit m_hit(input int pc);
        return m_valid[pc % N] && (m_tag[pc % N] == pc / N);
    endfunction

    function automatic int m_pred_taken(input int pc);
        return (m_hit(pc) && m_ctr[pc % N] >= 2) ? 1 : 0;
    endfunction

    function automatic int m_pred_target(input int pc);
        return m_pred_taken(pc) ? m_target[pc % N] : (pc + 1) % PC_MOD;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_branches = 0;
        m_mispredicts = 0;
    endtask

    task automatic m_update(input int pc, input int taken, input int target,
                            input int ptaken, input int ptarget);
        int i;
        i = pc % N;
        if (m_hit(pc)) begin
            if (taken != 0) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = target;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken != 0) begin
            m_valid[i] = 1; m_tag[i] = pc / N; m_target[i] = target; m_ctr[i] = 2;
        end
        m_branches++;
        if (ptaken != taken || (taken != 0 && ptarget != target)) m_mispredicts++;
    endtask

    // Called at a falling edge: drive, check lookup against the pre-edge
    // model, then let the rising edge train both DUT and model.
    task automatic cycle(input string tag, input int fpc, input int bv,
                         input int epc, input int taken, input int target,
                         input int ptaken, input int ptarget);
        F_pc = fpc[XLEN-1:0];
        EX_br_valid = bv[0];
        EX_pc = epc[XLEN-1:0];
        EX_actual_taken = taken[0];
        EX_actual_target = target[XLEN-1:0];
        EX_pred_taken = ptaken[0];
        EX_pred_target = ptarget[XLEN-1:0];
        #1;
        check({tag, ".taken"}, 32'(F_BP_taken), 32'(m_pred_taken(fpc)));
        check({tag, ".target"}, 32'(F_BP_target_pc), 32'(m_pred_target(fpc)));
        @(posedge clk);
        if (bv != 0) m_update(epc, taken, target, ptaken, ptarget);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        F_pc = 5'd3;
        EX_br_valid = 1'b0;
        EX_pc = '0;
        EX_actual_taken = 1'b0;
        EX_actual_target = '0;
        EX_pred_taken = 1'b0;
        EX_pred_target = '0;
        m_reset();

        // Reset state, including a branch presented while in reset.
        #2;
        check("rst_pc3.taken", 32'(F_BP_taken), 32'd0);
        check("rst_pc3.target", 32'(F_BP_target_pc), 32'd4);
        F_pc = 5'd31;
        #1;
        check("rst_pc31.target", 32'(F_BP_target_pc), 32'd0);
        EX_br_valid = 1'b1; EX_pc = 5'd3; EX_actual_taken = 1'b1; EX_actual_target = 5'd9;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        EX_br_valid = 1'b0;
        cycle("rst_ignore", 3, 0, 0, 0, 0, 0, 0);

        // Allocation with same-cycle lookup: pre-update contents seen.
        cycle("alloc_same", 6, 1, 6, 1, 20, 0, 7);
        check("alloc_next.const", 32'(F_BP_target_pc), 32'd20);
        cycle("alloc_next", 6, 0, 0, 0, 0, 0, 0);
        // Not taken once -> weak NT, predicts fall-through.
        cycle("nt1", 6, 1, 6, 0, 0, 1, 20);
        check("nt1.const", 32'(F_BP_target_pc), 32'd7);
        cycle("nt1_look", 6, 0, 0, 0, 0, 0, 0);
        // Three taken -> saturate strong T.
        for (int k = 0; k < 3; k++) cycle("t3", 6, 1, 6, 1, 20, 0, 7);
        cycle("nt_a", 6, 1, 6, 0, 0, 1, 20);
        cycle("nt_b", 6, 1, 6, 0, 0, 1, 20);
        check("after_2nt.const", 32'(F_BP_target_pc), 32'd7);
        cycle("after_2nt", 6, 0, 0, 0, 0, 0, 0);

        // Aliasing: 10 shares index 2 with 6 and evicts it.
        cycle("retrain6", 6, 1, 6, 1, 20, 0, 7);
        cycle("alias10", 6, 1, 10, 1, 1, 0, 11);
        cycle("alias_pc6", 6, 0, 0, 0, 0, 0, 0);
        check("alias_pc10.const", 32'(F_BP_target_pc), 32'd7);
        cycle("alias_pc10", 10, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-sequence, away from the clock edge.
        F_pc = 5'd10;
        #1;
        rst = 1'b1;
        #1;
        m_reset();
        check("midrst.taken", 32'(F_BP_taken), 32'd0);
        check("midrst.target", 32'(F_BP_target_pc), 32'd11);
        @(negedge clk);
        rst = 1'b0;
        cycle("post_rst", 10, 0, 0, 0, 0, 0, 0);

`ifdef BP_STATS_EN
        check("stat_clr.br", 32'(stat_branches), 32'd0);
        check("stat_clr.mis", 32'(stat_mispredicts), 32'd0);
        // 5 updates: 2 direction mismatches, 1 target-only mismatch.
        cycle("st1", 0, 1, 1, 1, 8, 0, 2);
        cycle("st2", 0, 1, 2, 0, 0, 1, 9);
        cycle("st3", 0, 1, 1, 1, 8, 1, 5);
        cycle("st4", 0, 1, 1, 1, 8, 1, 8);
        cycle("st5", 0, 1, 3, 0, 0, 0, 4);
        check("stat5.br", 32'(stat_branches), 32'd5);
        check("stat5.mis", 32'(stat_mispredicts), 32'd3);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            int epc, pt;
            epc = $urandom_range(PC_MOD - 1);
            pt = $urandom_range(1);
            cycle("rand", $urandom_range(PC_MOD - 1), ($urandom_range(3) != 0) ? 1 : 0,
                  epc, $urandom_range(1), $urandom_range(PC_MOD - 1),
                  pt, $urandom_range(PC_MOD - 1));
        end

`ifdef BP_STATS_EN
        check("stat_rand.br", 32'(stat_branches), 32'(m_branches % 65536));
        check("stat_rand.mis", 32'(stat_mispredicts), 32'(m_mispredicts % 65536));
        // Drive updates until the branch count reaches 65535, then one more.
        EX_br_valid = 1'b1; EX_pc = 5'd0; EX_actual_taken = 1'b0;
        EX_pred_taken = 1'b0;
        while ((m_branches % 65536) != 65535) begin
            @(posedge clk);
            m_update(0, 0, 0, 0, 0);
        end
        @(negedge clk);
        check("stat_max.br", 32'(stat_branches), 32'd65535);
        @(posedge clk);
        m_update(0, 0, 0, 0, 0);
        @(negedge clk);
        EX_br_valid = 1'b0;
        check("stat_wrap.br", 32'(stat_branches), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
